// File: rtl/signed_accum_if.sv
// ----------------------------------------------------------------------------
// signed_accum_if
//
// Stream bundle for signed_accum. It carries the sample input stream
// (in_valid/in_ready/in_data) and the block result stream
// (out_valid/out_ready/out_acc/out_ovf).
//
// Parameters
//   DATA_W : width of an incoming signed sample
//   ACC_W  : width of the block total
//
// Modports
//   master : the environment side. It produces samples and consumes results.
//   slave  : the accumulator side. It consumes samples and produces results.
// ----------------------------------------------------------------------------
interface signed_accum_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
);
    // Sample stream
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    // Result stream
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_acc,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_acc,
        output out_ovf
    );
endinterface

// File: rtl/signed_accum.sv
// ----------------------------------------------------------------------------
// signed_accum
//
// Block accumulator for two's-complement samples. Each accepted sample is
// sign-extended to ACC_W and added to a running total. After N_SAMPLES
// accepts, the total and a sticky overflow flag are held on the result stream
// until the consumer takes them.
//
// Compile-time option
//   SIGNED_ACCUM_SAT_EN : when defined, an overflowing step clamps the total
//                         to the most positive or most negative ACC_W value.
//                         When undefined, the total wraps modulo 2^ACC_W.
//                         The overflow flag is set in either case.
//
// Parameters
//   DATA_W    : sample width (must match bus.in_data)
//   ACC_W     : total width, >= DATA_W (must match bus.out_acc)
//   N_SAMPLES : samples per block, >= 1
//
// Ports
//   clk  : clock; all state changes on the rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous block abort; drops a partial or held block
//   bus  : slave side of signed_accum_if (sample and result streams)
//   busy : a block is in progress (>= 1 sample taken) or a result is held
// ----------------------------------------------------------------------------
module signed_accum #(
    parameter int DATA_W    = 4,
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    signed_accum_if.slave  bus,
    output logic           busy
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    // ------------------------------------------------------------------------
    // Datapath for one accumulate step
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0]   sample_ext;
    logic [ACC_W-1:0]   sum_raw;
    logic [ACC_W-1:0]   sum_step;
    logic               step_ovf;
    logic               accept;
    logic               last_sample;

    // A sized cast of a signed value sign-extends it.
    assign sample_ext = ACC_W'($signed(bus.in_data));
    assign sum_raw    = acc_q + sample_ext;

    // Signed overflow: the addends agree in sign but the result does not.
    assign step_ovf = (acc_q[ACC_W-1] == sample_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef SIGNED_ACCUM_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow the addends share a sign, so the sign of acc gives the
    // direction in which to clamp.
    assign sum_step = step_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    assign sum_step = sum_raw;
`endif

    // ------------------------------------------------------------------------
    // Handshake outputs. They depend only on state, so in_ready has no path
    // from in_valid and out_valid has no path from out_ready.
    // ------------------------------------------------------------------------
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = (cnt_q != '0) || (state_q == ST_HOLD);

    assign accept      = bus.in_valid && bus.in_ready;
    assign last_sample = (cnt_q == CNT_W'(N_SAMPLES - 1));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so
        // no path can leave a value unassigned and infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d = sum_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | step_ovf;
                    if (last_sample) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // The handshake cycle is the last HOLD cycle. Samples are not
                // taken in it because in_ready is still low.
                if (bus.out_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_ACC;
            end
        endcase

        // An abort overrides any accept or result handshake in this cycle.
        if (clr) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge and order of the
        // statements does not matter.
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/signed_accum.md
# signed_accum

Sequential stage directly downstream of the 4-bit `sign_adder`. It consumes the adder's two's-complement `sum` values over a valid/ready stream and sign-extends each one. It accumulates a block of `N_SAMPLES` values into a wider register, then presents the block total with a sticky overflow flag over a second valid/ready handshake. Accumulator overflow either wraps or saturates, selected at compile time.

## Interface
- `DATA_W`, 4, width of incoming signed samples (matches `sign_adder` `sum`).
- `ACC_W`, 8, accumulator/result width; must be >= `DATA_W`.
- `N_SAMPLES`, 4, samples per block; must be >= 1.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `clr` input 1: synchronous block abort; discards partial or held result.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block can accept a sample this cycle.
- `in_data` input `DATA_W`: signed two's-complement sample.
- `out_valid` output 1: block result available.
- `out_ready` input 1: consumer accepts result.
- `out_acc` output `ACC_W`: signed block total.
- `out_ovf` output 1: sticky; at least one accumulate step in this block overflowed `ACC_W`.
- `busy` output 1: at least one sample accepted in the current block, or a result is held.

## Operation
- Two states: ACC and HOLD. Reset state is ACC.
- ACC:
  - `in_ready`=1, `out_valid`=0.
  - Accept when `in_valid & in_ready`: `acc <= acc + sext(in_data)` and `cnt <= cnt+1`.
  - The accept that makes `cnt` equal `N_SAMPLES` moves the block to HOLD. `cnt` is `$clog2(N_SAMPLES+1)` bits.
- HOLD:
  - `in_ready`=0, `out_valid`=1.
  - `out_acc`/`out_ovf` are stable and `in_valid` is ignored.
  - On `out_ready`: `acc`, `cnt`, `ovf` clear to 0 and the block returns to ACC.
- Overflow rule: signed overflow occurs when both addends have the same sign and the `ACC_W`-bit result has a different sign. It sets `ovf`, which stays set until the block is consumed, `clr` is asserted, or `rst` is asserted.
- `out_acc` drives `acc` directly. `out_ovf` drives `ovf` directly.
- `busy` = (`cnt` != 0) | HOLD.
- `clr`: next cycle state=ACC and `acc`/`cnt`/`ovf`=0. It wins over a simultaneous accept or `out_ready`.
- `rst`: same effect as `clr`. It has priority over everything and is valid mid-block or in HOLD.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_acc`=0, `out_ovf`=0, `busy`=0.
- Latency: `out_valid` rises on the cycle after the last sample's accept edge. `out_acc` includes that last sample.
- HOLD exit: the `out_ready` handshake cycle is the last HOLD cycle. `in_ready` returns high the following cycle, and no sample is accepted in the handshake cycle.
- Minimum block period: `N_SAMPLES` + 1 cycles.
- `in_ready` does not depend combinationally on `in_valid`. `out_valid` does not depend combinationally on `out_ready`.
- Backpressure: HOLD persists indefinitely while `out_ready`=0.

## Configuration
- `SIGNED_ACCUM_SAT_EN` defined: on overflow, `acc` clamps to `2^(ACC_W-1)-1` for positive overflow or `-2^(ACC_W-1)` for negative overflow. Later samples in the block add to the clamped value. `ovf` still sets.
- `SIGNED_ACCUM_SAT_EN` undefined: `acc` wraps modulo `2^ACC_W`. `ovf` sets.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs → `in_ready`=1, `out_valid`=0, `out_acc`=8'h00, `out_ovf`=0, `busy`=0.
- Basic block, defaults: samples 4'h3, 4'hE, 4'h5, 4'hF on consecutive cycles → `out_valid`=1 on the next cycle, `out_acc`=8'h05, `out_ovf`=0.
- Backpressure: after the basic block, hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 → `out_acc` stays 8'h05 and `in_ready`=0. Then assert `out_ready` → `in_ready`=1 on the next cycle and `out_acc`=8'h00.
- Overflow, `N_SAMPLES`=20, 20 samples of 4'h7:
  - Without macro → `out_acc`=8'h8C, `out_ovf`=1.
  - With `SIGNED_ACCUM_SAT_EN` → `out_acc`=8'h7F, `out_ovf`=1.
- Abort: accept 4'h7 and 4'h7, then assert `clr` together with an `in_valid` sample → that sample is dropped. Then feed 4'h1 ×4 → `out_acc`=8'h04.
- Reset in HOLD: reach HOLD, then assert `rst` with `out_ready`=0 → next cycle `out_valid`=0, `out_acc`=0, `in_ready`=1.
